// File: rtl/pong_score.sv
// pong_score: BCD scorekeeper with match FSM and multiplexed 7-segment display driver
module pong_score #(
   parameter int WIN_SCORE      = 11,
   parameter bit WIN_BY_TWO     = 1'b0,
   parameter int REFRESH_DIV    = 25_000,
   parameter int BLINK_DIV      = 25_000_000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       point_left,
   input  logic       point_right,
   input  logic       clear,
   output logic [7:0] score_left,
   output logic [7:0] score_right,
   output logic       game_over,
   output logic       winner,
   output logic [6:0] seg,
   output logic [3:0] dig_sel
);
   localparam int RW = $clog2(REFRESH_DIV + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
   typedef enum logic {PLAY, OVER} state_t;
   state_t        r_state;
   logic [7:0]    r_score_l, r_score_r;
   logic          r_game_over, r_winner, r_ph;
   logic [BW-1:0] r_blk;
   logic [RW-1:0] r_ref;
   logic [1:0]    r_dig;
   logic [6:0]    r_seg;
   logic [3:0]    r_dig_sel;
   logic          w_inc_l, w_inc_r, w_win_l, w_win_r, w_ref_wrap, w_blank;
   logic [7:0]    w_nl, w_nr;
   logic [1:0]    w_dig_nxt;
   logic [3:0]    w_val;
   logic [6:0]    w_lit;

   function automatic logic [6:0] bin(input logic [7:0] b);
      return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
   endfunction

   // BCD increment that saturates at 99
   function automatic logic [7:0] bcd_inc(input logic [7:0] b);
      return (b == 8'h99) ? b : (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
   endfunction

   // s is the scorer's new score, o the opponent's; 99 always ends the match
   function automatic logic wins(input logic [7:0] s, input logic [7:0] o);
      return (s == 8'h99) || ((bin(s) >= 7'(WIN_SCORE)) &&
             (!WIN_BY_TWO || ({1'b0, bin(s)} >= {1'b0, bin(o)} + 8'd2)));
   endfunction

   // segments {g,f,e,d,c,b,a}, active-high
   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // scoring decode and the content of the digit that will be selected after this edge
   always_comb begin
      w_inc_l    = point_left & ~point_right;
      w_inc_r    = point_right & ~point_left;
      w_nl       = bcd_inc(r_score_l);
      w_nr       = bcd_inc(r_score_r);
      w_win_l    = wins(w_nl, r_score_r);
      w_win_r    = wins(w_nr, r_score_l);
      w_ref_wrap = (r_ref == REF_MAX);
      w_dig_nxt  = r_dig + 2'(w_ref_wrap);
      w_val      = w_dig_nxt[1] ? (w_dig_nxt[0] ? r_score_r[3:0] : r_score_r[7:4])
                                : (w_dig_nxt[0] ? r_score_l[3:0] : r_score_l[7:4]);
      w_blank    = (~w_dig_nxt[0] & (w_val == 4'd0)) |
                   ((r_state == OVER) & ~r_ph & (w_dig_nxt[1] == r_winner));
      w_lit      = w_blank ? 7'd0 : enc(w_val);
   end

   // match FSM: scores, winner and blink phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= PLAY;
         r_score_l   <= 8'h00;
         r_score_r   <= 8'h00;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
         r_blk       <= '0;
         r_ph        <= 1'b1;
      end else if (r_state == PLAY) begin
         if (clear) begin
            r_score_l <= 8'h00;
            r_score_r <= 8'h00;
         end else if (w_inc_l) begin
            r_score_l <= w_nl;
            if (w_win_l) begin
               r_state     <= OVER;
               r_game_over <= 1'b1;
               r_winner    <= 1'b0;
               r_blk       <= '0;
               r_ph        <= 1'b1;
            end
         end else if (w_inc_r) begin
            r_score_r <= w_nr;
            if (w_win_r) begin
               r_state     <= OVER;
               r_game_over <= 1'b1;
               r_winner    <= 1'b1;
               r_blk       <= '0;
               r_ph        <= 1'b1;
            end
         end
      end else if (clear) begin
         r_state     <= PLAY;
         r_score_l   <= 8'h00;
         r_score_r   <= 8'h00;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
      end else begin
         r_blk <= (r_blk == BLK_MAX) ? '0 : r_blk + BW'(1);
         if (r_blk == BLK_MAX) r_ph <= ~r_ph;
      end
   end

   // display refresh: digit select and segments registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref     <= '0;
         r_dig     <= 2'd0;
         r_seg     <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
         r_dig_sel <= SEG_ACTIVE_LOW ? 4'b1110 : 4'b0001;
      end else begin
         r_ref     <= w_ref_wrap ? '0 : r_ref + RW'(1);
         r_dig     <= w_dig_nxt;
         r_seg     <= SEG_ACTIVE_LOW ? ~w_lit : w_lit;
         r_dig_sel <= SEG_ACTIVE_LOW ? ~(4'b0001 << w_dig_nxt) : (4'b0001 << w_dig_nxt);
      end
   end

   assign score_left  = r_score_l;
   assign score_right = r_score_r;
   assign game_over   = r_game_over;
   assign winner      = r_winner;
   assign seg         = r_seg;
   assign dig_sel     = r_dig_sel;
endmodule

// File: tb/tb_pong_score.sv
// tb_pong_score: directed and random stimulus on four pong_score variants against an integer score model
module tb_pong_score;
   localparam int NI = 4;
   localparam int WS [NI] = '{3, 3, 99, 3};
   localparam bit WB [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
   localparam bit AL [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic clk = 1'b0, rst_n = 1'b1, pl = 1'b0, pr = 1'b0, cl = 1'b0;
   logic [7:0] sl [NI];
   logic [7:0] sr [NI];
   logic       go [NI];
   logic       wn [NI];
   logic [6:0] sg [NI];
   logic [3:0] ds [NI];
   int ml [NI], mr [NI], me [NI];
   bit mo [NI], mw [NI];
   logic [6:0] es [NI];
   logic [3:0] ed [NI];
   int n, n_tests, n_fail;

   always #5 clk = ~clk;

   pong_score #(.WIN_SCORE(3), .WIN_BY_TWO(1'b0), .REFRESH_DIV(4), .BLINK_DIV(8), .SEG_ACTIVE_LOW(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .point_left(pl), .point_right(pr), .clear(cl),
      .score_left(sl[0]), .score_right(sr[0]), .game_over(go[0]), .winner(wn[0]), .seg(sg[0]), .dig_sel(ds[0]));
   pong_score #(.WIN_SCORE(3), .WIN_BY_TWO(1'b1), .REFRESH_DIV(4), .BLINK_DIV(8), .SEG_ACTIVE_LOW(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .point_left(pl), .point_right(pr), .clear(cl),
      .score_left(sl[1]), .score_right(sr[1]), .game_over(go[1]), .winner(wn[1]), .seg(sg[1]), .dig_sel(ds[1]));
   pong_score #(.WIN_SCORE(99), .WIN_BY_TWO(1'b0), .REFRESH_DIV(4), .BLINK_DIV(8), .SEG_ACTIVE_LOW(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .point_left(pl), .point_right(pr), .clear(cl),
      .score_left(sl[2]), .score_right(sr[2]), .game_over(go[2]), .winner(wn[2]), .seg(sg[2]), .dig_sel(ds[2]));
   pong_score #(.WIN_SCORE(3), .WIN_BY_TWO(1'b0), .REFRESH_DIV(4), .BLINK_DIV(8), .SEG_ACTIVE_LOW(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .point_left(pl), .point_right(pr), .clear(cl),
      .score_left(sl[3]), .score_right(sr[3]), .game_over(go[3]), .winner(wn[3]), .seg(sg[3]), .dig_sel(ds[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
      end
   endtask

   function automatic logic [7:0] bcd(input int s);
      return 8'((s / 10) * 16 + s % 10);
   endfunction

   function automatic bit wins(input int k, input int s, input int o);
      return (s == 99) || (s >= WS[k] && (!WB[k] || s >= o + 2));
   endfunction

   task automatic model_reset();
      n = 0;
      for (int k = 0; k < NI; k++) begin
         ml[k] = 0; mr[k] = 0; mo[k] = 1'b0; mw[k] = 1'b0; me[k] = 0;
         es[k] = AL[k] ? 7'h7F : 7'h00;
         ed[k] = AL[k] ? 4'b1110 : 4'b0001;
      end
   endtask

   // display after edge n: digit (n/4)%4, content from the score state before the edge
   task automatic model_edge(input bit l, input bit r, input bit c);
      int idx, v;
      bit on, blank;
      logic [6:0] lit;
      logic [3:0] one;
      n++;
      idx = (n / 4) % 4;
      one = 4'(1 << idx);
      for (int k = 0; k < NI; k++) begin
         on = !mo[k] || (((n - 1 - me[k]) / 8) % 2 == 0);
         v = (idx == 0) ? ml[k] / 10 : (idx == 1) ? ml[k] % 10 : (idx == 2) ? mr[k] / 10 : mr[k] % 10;
         blank = (idx % 2 == 0 && v == 0) || (mo[k] && !on && (idx / 2 == int'(mw[k])));
         lit = blank ? 7'h00 : SEGT[v];
         es[k] = AL[k] ? ~lit : lit;
         ed[k] = AL[k] ? ~one : one;
         if (!mo[k]) begin
            if (c) begin
               ml[k] = 0; mr[k] = 0;
            end else if (l && !r) begin
               ml[k] = (ml[k] < 99) ? ml[k] + 1 : 99;
               if (wins(k, ml[k], mr[k])) begin mo[k] = 1'b1; mw[k] = 1'b0; me[k] = n; end
            end else if (r && !l) begin
               mr[k] = (mr[k] < 99) ? mr[k] + 1 : 99;
               if (wins(k, mr[k], ml[k])) begin mo[k] = 1'b1; mw[k] = 1'b1; me[k] = n; end
            end
         end else if (c) begin
            mo[k] = 1'b0; mw[k] = 1'b0; ml[k] = 0; mr[k] = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("u%0d.score_left", k), 32'(sl[k]), 32'(bcd(ml[k])));
         chk($sformatf("u%0d.score_right", k), 32'(sr[k]), 32'(bcd(mr[k])));
         chk($sformatf("u%0d.game_over", k), 32'(go[k]), 32'(mo[k]));
         chk($sformatf("u%0d.winner", k), 32'(wn[k]), 32'(mw[k]));
         chk($sformatf("u%0d.seg", k), 32'(sg[k]), 32'(es[k]));
         chk($sformatf("u%0d.dig_sel", k), 32'(ds[k]), 32'(ed[k]));
      end
   endtask

   task automatic step(input bit l, input bit r, input bit c);
      pl = l; pr = r; cl = c;
      model_edge(l, r, c);
      @(negedge clk);
      check_all();
      pl = 1'b0; pr = 1'b0; cl = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      repeat (20) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); end
      repeat (24) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0); end
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
      repeat (30) step(1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (99) step(1'b0, 1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
